alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Round-robin scheduler that shares one ALU datapath among NUM_REQ requesters.
- Accepts one operation (opcode, a, b) per grant using a valid/ready handshake.
- Issues the operation to the ALU as a single-cycle vld pulse and captures the ALU result one clock later.
- Returns the result on a response channel tagged with the requester index. Sits between bus-side masters and the ALU inside the test DUT.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand and result width; must match the ALU.
- OPC_W, 3, opcode width.
- ID_W, 2, requester index width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_opcode  in  NUM_REQ*OPC_W  packed opcodes; requester i occupies slice [i*OPC_W +: OPC_W].
- req_a  in  NUM_REQ*DATA_W  packed operand a.
- req_b  in  NUM_REQ*DATA_W  packed operand b.
- req_rdy  out  NUM_REQ  one-hot accept strobe.
- alu_vld  out  1  ALU issue strobe.
- alu_opcode  out  OPC_W  opcode to the ALU.
- alu_a  out  DATA_W  operand a to the ALU.
- alu_b  out  DATA_W  operand b to the ALU.
- alu_out  in  DATA_W  ALU registered result.
- alu_opVld  in  1  ALU output valid (sticky in the ALU; informational only).
- rsp_vld  out  1  response valid.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  DATA_W  result.
- rsp_err  out  1  illegal-opcode flag.
- rsp_rdy  in  1  response consumer ready.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- Reset values:
  - All outputs 0.
  - rr_ptr = 0.
  - Operand, result and id registers 0.
- Reset mid-operation: the in-flight operation is dropped and no response is produced; requesters re-present their requests after reset.
- IDLE:
  - If any req_vld is high, select winner g = first index with req_vld set, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Assert req_rdy[g] combinationally in the same cycle; the handshake completes when req_vld[g] & req_rdy[g].
  - On that edge: latch opcode/a/b/g, set rr_ptr = (g+1) mod NUM_REQ, go to ISSUE.
  - req_rdy is 0 in every other state. Requesters hold vld and operands stable until accepted.
- ISSUE:
  - alu_vld = 1 for exactly one cycle.
  - alu_opcode/alu_a/alu_b driven from the latched registers; these hold their values in all other states.
  - Next state WAIT.
- WAIT:
  - The ALU result becomes valid on this cycle (fixed one-cycle ALU latency).
  - On this edge capture alu_out into rsp_data. alu_opVld is not used for timing because it is sticky.
  - Next state RESP.
- RESP:
  - rsp_vld = 1; rsp_id, rsp_data and rsp_err are held stable.
  - When rsp_rdy = 1 on an edge: go to IDLE.
  - Back-pressure holds the FSM in RESP indefinitely; no new grant is made.
- Timing:
  - Minimum accept-to-accept spacing: 4 cycles.
  - Accept-to-rsp_vld latency: 3 cycles.
- Fairness: a requester whose req_vld is continuously asserted is granted within NUM_REQ grants.
- Width rules:
  - Results are DATA_W wide, truncated modulo 2**DATA_W (add/sub wrap, no carry out).
  - NOT uses operand a only; operand b is forwarded unchanged.
- rr_ptr wrap: NUM_REQ-1 → 0.

Optional Feature:
- Macro: ALU_SCHED_OPCHK_EN.
- Defined:
  - Opcodes outside 1..6 are accepted but not issued to the ALU.
  - The FSM goes IDLE → RESP directly, with rsp_data = 0 and rsp_err = 1.
  - Legal opcodes behave as above with rsp_err = 0.
- Undefined: all opcodes are issued unchanged and rsp_err is tied to 0. The response data for an illegal opcode is whatever the ALU holds.

Test Plan:
- Single op: req_vld[0], opcode 1, a = 16'h0003, b = 16'h0004 → req_rdy[0] pulse; alu_vld 1 cycle later; rsp_vld 3 cycles after accept with rsp_id = 0, rsp_data = 16'h0007.
- Wrap: opcode 2, a = 16'h0000, b = 16'h0001 on req 2 → rsp_data = 16'hFFFF, rsp_id = 2. Also opcode 1, a = 16'hFFFF, b = 16'h0002 → 16'h0001.
- Fairness: all four req_vld held high with rr_ptr = 0 and rsp_rdy = 1 → grants in order 0, 1, 2, 3, 0; accepts 4 cycles apart.
- Back-pressure: rsp_rdy = 0 for 10 cycles with req 1 pending → rsp_vld and data stable; req_rdy[1] stays 0 until one cycle after rsp_rdy rises.
- Reset mid-op: assert reset during WAIT → all outputs 0 immediately (asynchronous); no rsp_vld after release; next grant starts from index 0.
- With ALU_SCHED_OPCHK_EN: opcode 7 on req 3 → alu_vld never pulses; rsp_vld 1 cycle after accept with rsp_err = 1, rsp_data = 0, rsp_id = 3.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU among NUM_REQ requesters.
// Ports: req_* in (valid/op/a/b), req_rdy one-hot accept; alu_* issue/result;
// rsp_* tagged response with valid/ready. Async active-high reset.
// Optional macro ALU_SCHED_OPCHK_EN: opcodes outside 1..6 answered with
// rsp_err=1, rsp_data=0 and never issued to the ALU.
module alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      alu_vld,
  output logic [OPC_W-1:0]          alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_opVld,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      rsp_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   id_q;
  logic [ID_W:0]     cand;
  logic              gnt_any;
  logic              accept;
  logic              illegal;
  logic [OPC_W-1:0]  gnt_opc;
  logic [OPC_W-1:0]  opc_q;
  logic [DATA_W-1:0] gnt_a;
  logic [DATA_W-1:0] gnt_b;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] data_q;
  logic              unused_opvld;

  // Result timing is fixed by ALU latency; the sticky valid carries no info.
  assign unused_opvld = alu_opVld;

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ for the first valid request.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_vld[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = cand[ID_W-1:0];
      end
    end
  end

  assign gnt_opc = req_opcode[int'(gnt_id)*OPC_W +: OPC_W];
  assign gnt_a   = req_a[int'(gnt_id)*DATA_W +: DATA_W];
  assign gnt_b   = req_b[int'(gnt_id)*DATA_W +: DATA_W];

  // Gated by reset so every output reads 0 while reset is held.
  assign accept = (state == IDLE) && gnt_any && !reset;

  always_comb begin
    req_rdy = '0;
    if (accept)
      req_rdy[gnt_id] = 1'b1;
  end

`ifdef ALU_SCHED_OPCHK_EN
  assign illegal = (gnt_opc == '0) || (gnt_opc > OPC_W'(6));
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      opc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0
                                                : gnt_id + ID_W'(1);
        id_q   <= gnt_id;
        if (!illegal) begin
          opc_q <= gnt_opc;
          a_q   <= gnt_a;
          b_q   <= gnt_b;
        end
      end
      if (accept && illegal)
        data_q <= '0;
      else if (state == WAIT)
        data_q <= alu_out;
    end
  end

`ifdef ALU_SCHED_OPCHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (accept)
      err_q <= illegal;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_vld    = (state == ISSUE);
  assign alu_opcode = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_vld    = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: bench for alu_sched with a one-cycle registered ALU model
// and a queue-based reference of grants and responses.
module tb_alu_sched;
  localparam int N = 4;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
    int          age;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_vld = '0;
  logic [N*3-1:0]  req_opcode = '0;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic [N-1:0]    req_rdy;
  logic            alu_vld;
  logic [2:0]      alu_opcode;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic [15:0]     alu_out = '0;
  logic            alu_opVld = 1'b0;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;
  logic            rsp_err;
  logic            rsp_rdy = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0]  op_r [N];
  logic [15:0] a_r  [N];
  logic [15:0] b_r  [N];

  always #5 clk = ~clk;

  alu_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_vld    (req_vld),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rdy    (req_rdy),
    .alu_vld    (alu_vld),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_opVld  (alu_opVld),
    .rsp_vld    (rsp_vld),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_rdy    (rsp_rdy)
  );

  function automatic logic [15:0] ref_alu(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
`ifdef ALU_SCHED_OPCHK_EN
    return (op == 3'd0) || (op == 3'd7);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] rnd_op();
`ifdef ALU_SCHED_OPCHK_EN
    return 3'($urandom_range(0, 7));
`else
    return 3'($urandom_range(1, 6));
`endif
  endfunction

  // External ALU: registered result one cycle after the issue strobe.
  always @(posedge clk) begin
    if (alu_vld) begin
      alu_out   <= ref_alu(alu_opcode, alu_a, alu_b);
      alu_opVld <= 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    req_opcode[id*3 +: 3] = op;
    req_a[id*16 +: 16]    = a;
    req_b[id*16 +: 16]    = b;
    req_vld[id]           = 1'b1;
  endtask

  function automatic logic [59:0] all_outs();
    return {req_rdy, alu_vld, alu_opcode, alu_a, alu_b,
            rsp_vld, rsp_id, rsp_data, rsp_err};
  endfunction

  // Drives one request and collects what the DUT answers; no judging here.
  task automatic issue_one(input int id, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [15:0] data,
                           output logic [1:0] rid, output logic err,
                           output int pulses, output bit ok);
    bit got;
    ok = 0; lat = -1; data = '0; rid = '0; err = 1'b0; pulses = 0;
    got = 0;
    set_req(id, op, a, b);
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (req_rdy[id]) got = 1;
      @(posedge clk);
      #1;
    end
    req_vld[id] = 1'b0;
    if (!got) return;
    for (int k = 1; k <= 40; k++) begin
      if (alu_vld) pulses++;
      if (rsp_vld) begin
        lat = k; data = rsp_data; rid = rsp_id; err = rsp_err; ok = 1;
        break;
      end
      tick;
    end
    if (ok) tick;
  endtask

  task automatic test_reset;
    logic [59:0] ov;
    reset = 1'b1; req_vld = '0; rsp_rdy = 1'b1;
    tick; tick;
    ov = all_outs();
    vectors++;
    if (ov !== 60'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=0", ov);
    end
    reset = 1'b0;
    tick;
    ov = all_outs();
    vectors++;
    if (ov !== 60'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle got=%h exp=0", ov);
    end
  endtask

  task automatic test_single;
    set_req(0, 3'd1, 16'h0003, 16'h0004);
    #1;
    vectors++;
    if (req_rdy !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_rdy got=%b exp=0001", req_rdy);
    end
    tick;
    req_vld[0] = 1'b0;
    vectors++;
    if (alu_vld !== 1'b1 || alu_opcode !== 3'd1 || alu_a !== 16'h0003
        || alu_b !== 16'h0004 || req_rdy !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_issue got vld=%b op=%0d a=%h b=%h rdy=%b exp 1 1 0003 0004 0000",
               alu_vld, alu_opcode, alu_a, alu_b, req_rdy);
    end
    tick;
    vectors++;
    if (alu_vld !== 1'b0 || rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wait got alu_vld=%b rsp_vld=%b exp 0 0", alu_vld, rsp_vld);
    end
    tick;
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0007
        || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_rsp got vld=%b id=%0d data=%h err=%b exp 1 0 0007 0",
               rsp_vld, rsp_id, rsp_data, rsp_err);
    end
    tick;
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done got rsp_vld=%b exp 0", rsp_vld);
    end
  endtask

  task automatic test_wrap;
    int lat, pulses; logic [15:0] d; logic [1:0] rid; logic err; bit ok;
    issue_one(2, 3'd2, 16'h0000, 16'h0001, lat, d, rid, err, pulses, ok);
    vectors++;
    if (!ok || d !== 16'hFFFF || rid !== 2'd2 || lat != 3 || pulses != 1) begin
      miscompares++;
      $display("FAIL wrap_sub got ok=%0d data=%h id=%0d lat=%0d pulses=%0d exp 1 ffff 2 3 1",
               ok, d, rid, lat, pulses);
    end
    issue_one(1, 3'd1, 16'hFFFF, 16'h0002, lat, d, rid, err, pulses, ok);
    vectors++;
    if (!ok || d !== 16'h0001 || rid !== 2'd1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_add got ok=%0d data=%h id=%0d err=%b exp 1 0001 1 0",
               ok, d, rid, err);
    end
  endtask

  task automatic test_fair;
    int gid[$]; int gcyc[$]; exp_t fq[$]; exp_t e;
    int n, w; bit done;
    reset = 1'b1; tick; reset = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_r[i] = 3'($urandom_range(1, 6));
      a_r[i] = 16'($urandom()); b_r[i] = 16'($urandom());
      set_req(i, op_r[i], a_r[i], b_r[i]);
    end
    n = 0; done = 0;
    while (!done && n < 80) begin
      #1;
      w = -1;
      for (int i = 0; i < N; i++) if (req_rdy[i]) w = i;
      if (w >= 0) begin
        gid.push_back(w); gcyc.push_back(n);
        e.id = w; e.data = ref_alu(op_r[w], a_r[w], b_r[w]);
        e.err = 1'b0; e.age = 0;
        fq.push_back(e);
      end
      if (rsp_vld) begin
        vectors++;
        if (fq.size() == 0) begin
          miscompares++;
          $display("FAIL fair_spurious_rsp got id=%0d exp none", rsp_id);
        end else begin
          e = fq.pop_front();
          if (rsp_id !== 2'(e.id) || rsp_data !== e.data) begin
            miscompares++;
            $display("FAIL fair_rsp got id=%0d data=%h exp %0d %h",
                     rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (w >= 0) begin
        if (gid.size() >= 5) req_vld = '0;
        else begin
          op_r[w] = 3'($urandom_range(1, 6));
          a_r[w] = 16'($urandom()); b_r[w] = 16'($urandom());
          set_req(w, op_r[w], a_r[w], b_r[w]);
        end
      end
      n++;
      if (gid.size() >= 5 && fq.size() == 0) done = 1;
    end
    req_vld = '0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL fair_timeout got grants=%0d exp 5", gid.size());
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= gid.size() || gid[i] != i % N) begin
        miscompares++;
        $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i,
                 (i < gid.size()) ? gid[i] : -1, i % N);
      end
    end
    for (int i = 1; i < 5 && i < gcyc.size(); i++) begin
      vectors++;
      if (gcyc[i] - gcyc[i-1] != 4) begin
        miscompares++;
        $display("FAIL fair_spacing idx=%0d got=%0d exp=4", i, gcyc[i] - gcyc[i-1]);
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [15:0] e0, e1; bit got;
    rsp_rdy = 1'b0;
    op_r[0] = 3'($urandom_range(1, 6));
    a_r[0] = 16'($urandom()); b_r[0] = 16'($urandom());
    e0 = ref_alu(op_r[0], a_r[0], b_r[0]);
    set_req(0, op_r[0], a_r[0], b_r[0]);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_rdy[0]) got = 1;
      @(posedge clk);
      #1;
    end
    req_vld[0] = 1'b0;
    op_r[1] = 3'($urandom_range(1, 6));
    a_r[1] = 16'($urandom()); b_r[1] = 16'($urandom());
    e1 = ref_alu(op_r[1], a_r[1], b_r[1]);
    set_req(1, op_r[1], a_r[1], b_r[1]);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL bp_grant got no accept exp req_rdy[0]");
    end
    for (int k = 0; k < 20; k++) begin
      if (rsp_vld) break;
      tick;
    end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (rsp_vld !== 1'b1 || rsp_data !== e0 || rsp_id !== 2'd0
          || req_rdy !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d got vld=%b data=%h id=%0d rdy=%b exp 1 %h 0 0000",
                 c, rsp_vld, rsp_data, rsp_id, req_rdy, e0);
      end
      tick;
    end
    rsp_rdy = 1'b1;
    #1;
    vectors++;
    if (req_rdy !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_same_cycle got rdy=%b exp 0000", req_rdy);
    end
    tick;
    vectors++;
    if (req_rdy !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_after_rise got rdy=%b exp 0010", req_rdy);
    end
    tick;
    req_vld[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_vld) break;
      tick;
    end
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== e1) begin
      miscompares++;
      $display("FAIL bp_second_rsp got vld=%b id=%0d data=%h exp 1 1 %h",
               rsp_vld, rsp_id, rsp_data, e1);
    end
    tick;
  endtask

  task automatic test_random;
    exp_t q[$]; exp_t e;
    bit pend[N];
    int ptr, w, j;
    logic [N-1:0] exp_rdy;
    logic exp_rsp, exp_alu;
    reset = 1'b1; tick; reset = 1'b0;
    req_vld = '0; rsp_rdy = 1'b1; ptr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          op_r[i] = rnd_op();
          a_r[i] = 16'($urandom()); b_r[i] = 16'($urandom());
          set_req(i, op_r[i], a_r[i], b_r[i]);
        end
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      if (q.size() == 0) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (w < 0 && pend[j]) w = j;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_rsp = (q.size() > 0) && (q[0].age >= (q[0].err ? 1 : 3));
      exp_alu = (q.size() > 0) && !q[0].err && (q[0].age == 1);
      vectors++;
      if (req_rdy !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, req_rdy, exp_rdy);
      end
      vectors++;
      if (rsp_vld !== exp_rsp || alu_vld !== exp_alu) begin
        miscompares++;
        $display("FAIL rand_strobes cyc=%0d got rsp=%b alu=%b exp %b %b",
                 c, rsp_vld, alu_vld, exp_rsp, exp_alu);
      end
      if (exp_rsp && rsp_vld) begin
        vectors++;
        if (rsp_id !== 2'(q[0].id) || rsp_data !== q[0].data
            || rsp_err !== q[0].err) begin
          miscompares++;
          $display("FAIL rand_rsp cyc=%0d got id=%0d data=%h err=%b exp %0d %h %b",
                   c, rsp_id, rsp_data, rsp_err, q[0].id, q[0].data, q[0].err);
        end
      end
      @(posedge clk);
      #1;
      if (exp_rsp && rsp_rdy) void'(q.pop_front());
      foreach (q[k]) q[k].age++;
      if (w >= 0) begin
        e.id = w;
        e.err = is_illegal(op_r[w]);
        e.data = e.err ? 16'h0000 : ref_alu(op_r[w], a_r[w], b_r[w]);
        e.age = 1;
        q.push_back(e);
        ptr = (w + 1) % N;
        pend[w] = 0;
        req_vld[w] = 1'b0;
      end
    end
    req_vld = '0; rsp_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      if (rsp_vld) begin
        vectors++;
        if (rsp_id !== 2'(q[0].id) || rsp_data !== q[0].data) begin
          miscompares++;
          $display("FAIL rand_drain_rsp got id=%0d data=%h exp %0d %h",
                   rsp_id, rsp_data, q[0].id, q[0].data);
        end
        void'(q.pop_front());
      end
      tick;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain got pending=%0d exp 0", q.size());
    end
  endtask

  task automatic test_reset_midop;
    logic [59:0] ov; bit got; logic [15:0] e0;
    rsp_rdy = 1'b1;
    set_req(2, 3'd3, 16'h5A5A, 16'h0FF0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_rdy[2]) got = 1;
      @(posedge clk);
      #1;
    end
    req_vld[2] = 1'b0;
    vectors++;
    if (!got || alu_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_issue got accept=%0d alu_vld=%b exp 1 1", got, alu_vld);
    end
    tick;
    reset = 1'b1;
    req_vld[1] = 1'b1;
    #1;
    ov = all_outs();
    vectors++;
    if (ov !== 60'd0) begin
      miscompares++;
      $display("FAIL rst_async_outputs got=%h exp=0", ov);
    end
    req_vld = '0;
    tick; tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (rsp_vld !== 1'b0 || alu_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_rsp cyc=%0d got rsp=%b alu=%b exp 0 0", c, rsp_vld, alu_vld);
      end
      tick;
    end
    e0 = ref_alu(3'd4, 16'h1200, 16'h0034);
    set_req(3, 3'd1, 16'h0001, 16'h0001);
    set_req(0, 3'd4, 16'h1200, 16'h0034);
    #1;
    vectors++;
    if (req_rdy !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_ptr_cleared got rdy=%b exp 0001", req_rdy);
    end
    tick;
    req_vld = '0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_vld) break;
      tick;
    end
    vectors++;
    if (rsp_vld !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== e0) begin
      miscompares++;
      $display("FAIL rst_next_rsp got vld=%b id=%0d data=%h exp 1 0 %h",
               rsp_vld, rsp_id, rsp_data, e0);
    end
    tick;
  endtask

  task automatic test_opchk;
    int lat, pulses; logic [15:0] d; logic [1:0] rid; logic err; bit ok;
    issue_one(3, 3'd7, 16'h1234, 16'h4321, lat, d, rid, err, pulses, ok);
`ifdef ALU_SCHED_OPCHK_EN
    vectors++;
    if (!ok || pulses != 0 || lat != 1 || err !== 1'b1 || d !== 16'h0000
        || rid !== 2'd3) begin
      miscompares++;
      $display("FAIL opchk_illegal got ok=%0d pulses=%0d lat=%0d err=%b data=%h id=%0d exp 1 0 1 1 0000 3",
               ok, pulses, lat, err, d, rid);
    end
    issue_one(3, 3'd5, 16'h00FF, 16'h0F0F, lat, d, rid, err, pulses, ok);
    vectors++;
    if (!ok || pulses != 1 || lat != 3 || err !== 1'b0 || d !== 16'h0FF0) begin
      miscompares++;
      $display("FAIL opchk_legal got ok=%0d pulses=%0d lat=%0d err=%b data=%h exp 1 1 3 0 0ff0",
               ok, pulses, lat, err, d);
    end
`else
    vectors++;
    if (!ok || pulses != 1 || lat != 3 || err !== 1'b0 || rid !== 2'd3) begin
      miscompares++;
      $display("FAIL opchk_off_issue got ok=%0d pulses=%0d lat=%0d err=%b id=%0d exp 1 1 3 0 3",
               ok, pulses, lat, err, rid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fair();
    test_back_pressure();
    test_random();
    test_reset_midop();
    test_opchk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
